// File: rtl/wave_osc.sv
// -----------------------------------------------------------------------------
// wave_osc -- parametrised bipolar audio oscillator
//
// Generates one signed sample per enabled clock in one of four shapes:
// square, pulse (programmable duty), sawtooth or triangle. The period is
// programmable in clock cycles. Period, shape and duty are sampled only at
// the start of a period, so mid-period changes never distort a cycle that
// is already running.
//
// Ports
//   clk          in   1      system clock, all state changes on posedge
//   reset        in   1      synchronous active-high reset
//   enable       in   1      1 = advance oscillator, 0 = hold all state
//   sync         in   1      phase restart, counter forced to 0
//   mode         in   2      00 square, 01 pulse, 10 saw, 11 triangle
//   wave_length  in   CNT_W  period in clock cycles (0 and 1 act as 2)
//   duty         in   8      pulse high time = (P*duty)>>8 cycles
//   out          out  OUT_W  signed sample, range -A..+A, A = 1<<AMP_SHIFT
//   period_tick  out  1      one-cycle pulse after each period wrap
//
// Priority on each clock edge: reset, then sync, then enable.
// The sample in out lags the phase counter by one cycle: the edge that sees
// counter == c writes f(c) into out.
// -----------------------------------------------------------------------------
module wave_osc #(
  parameter int OUT_W     = 32,
  parameter int CNT_W     = 32,
  parameter int AMP_SHIFT = 20
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    sync,
  input  logic [1:0]              mode,
  input  logic [CNT_W-1:0]        wave_length,
  input  logic [7:0]              duty,
  output logic signed [OUT_W-1:0] out,
  output logic                    period_tick
);

  // Two guard bits above the output width so intermediate sums can exceed
  // +/-A without wrapping before they are saturated.
  localparam int ACC_W = OUT_W + 2;
  // The step divider needs room for 2*A and for any period value.
  localparam int DIV_W = ((CNT_W > ACC_W) ? CNT_W : ACC_W) + 1;

  localparam logic signed [ACC_W-1:0] AMP_POS =
    {{(ACC_W-1){1'b0}}, 1'b1} << AMP_SHIFT;
  localparam logic signed [ACC_W-1:0] AMP_NEG = -AMP_POS;
  localparam logic [DIV_W-1:0] TWO_A =
    {{(DIV_W-1){1'b0}}, 1'b1} << (AMP_SHIFT + 1);
  localparam logic [CNT_W-1:0] MIN_P = CNT_W'(2);

  typedef enum logic [1:0] {
    MODE_SQUARE = 2'b00,
    MODE_PULSE  = 2'b01,
    MODE_SAW    = 2'b10,
    MODE_TRI    = 2'b11
  } mode_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0]        cnt_q,  cnt_d;    // phase counter, 0..P-1
  logic [CNT_W-1:0]        p_q;              // latched period P
  logic [CNT_W-1:0]        h_q;              // latched pulse high time H
  logic signed [ACC_W-1:0] step_q;           // latched saw step (2A)/P
  mode_e                   mode_q;           // latched waveform shape
  logic signed [ACC_W-1:0] acc_q;            // unsaturated value of f(c-1)
  logic signed [OUT_W-1:0] out_q,  out_d;
  logic                    tick_q, tick_d;

  // ---------------------------------------------------------------------------
  // Values that would be latched at the start of a period
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0]        p_live;
  logic [CNT_W+7:0]        h_prod;
  logic [CNT_W-1:0]        h_live;
  logic signed [ACC_W-1:0] step_live;
  logic [DIV_W-1:0]        p_ext;

  always_comb begin
    p_live    = (wave_length < MIN_P) ? MIN_P : wave_length;
    h_prod    = {8'd0, p_live} * {{CNT_W{1'b0}}, duty};
    h_live    = CNT_W'(h_prod >> 8);
    p_ext     = {{(DIV_W-CNT_W){1'b0}}, p_live};
    step_live = ACC_W'(TWO_A / p_ext);
  end

  // ---------------------------------------------------------------------------
  // Effective parameters for this edge: at counter 0 the freshly latched
  // values already shape the sample produced on the same edge.
  // ---------------------------------------------------------------------------
  logic                    at_start;
  logic [CNT_W-1:0]        cur_p;
  logic [CNT_W-1:0]        cur_h;
  logic signed [ACC_W-1:0] cur_step;
  mode_e                   cur_mode;
  logic [CNT_W-1:0]        half;
  logic                    last;

  always_comb begin
    at_start = (cnt_q == '0);
    cur_p    = at_start ? p_live            : p_q;
    cur_h    = at_start ? h_live            : h_q;
    cur_step = at_start ? step_live         : step_q;
    cur_mode = at_start ? mode_e'(mode)     : mode_q;
    half     = cur_p >> 1;
    last     = (cnt_q == (cur_p - CNT_W'(1)));
  end

  // ---------------------------------------------------------------------------
  // Waveform generation
  // Saw and triangle are built incrementally from the previous sample held in
  // acc_q, which avoids a counter-by-step multiplier. Both reload -A at the
  // start of a period; the triangle reloads +A at the turning point so that
  // the falling half is exactly +A - (c-half)*2*step.
  // ---------------------------------------------------------------------------
  logic signed [ACC_W-1:0] two_step;
  logic signed [ACC_W-1:0] saw_val;
  logic signed [ACC_W-1:0] tri_val;
  logic signed [ACC_W-1:0] raw_val;
  logic signed [ACC_W-1:0] sat_val;

  always_comb begin
    two_step = cur_step <<< 1;

    if (at_start) begin
      saw_val = AMP_NEG;
    end else begin
      saw_val = acc_q + cur_step;
    end

    if (at_start) begin
      tri_val = AMP_NEG;
    end else if (cnt_q < half) begin
      tri_val = acc_q + two_step;
    end else if (cnt_q == half) begin
      tri_val = AMP_POS;
    end else begin
      tri_val = acc_q - two_step;
    end

    unique case (cur_mode)
      MODE_SQUARE: raw_val = (cnt_q < half)  ? AMP_NEG : AMP_POS;
      MODE_PULSE:  raw_val = (cnt_q < cur_h) ? AMP_POS : AMP_NEG;
      MODE_SAW:    raw_val = saw_val;
      MODE_TRI:    raw_val = tri_val;
      default:     raw_val = AMP_NEG;
    endcase

    // Clamp to the legal amplitude range; the output never wraps.
    if (raw_val > AMP_POS) begin
      sat_val = AMP_POS;
    end else if (raw_val < AMP_NEG) begin
      sat_val = AMP_NEG;
    end else begin
      sat_val = raw_val;
    end

    out_d  = OUT_W'(sat_val);
    tick_d = last;
    cnt_d  = last ? '0 : (cnt_q + CNT_W'(1));
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      out_q  <= '0;
      tick_q <= 1'b0;
      p_q    <= MIN_P;
      h_q    <= '0;
      step_q <= '0;
      mode_q <= MODE_SQUARE;
      acc_q  <= '0;
    end else if (sync) begin
      // Phase restart only; the next enabled edge re-latches the parameters.
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else if (enable) begin
      if (at_start) begin
        p_q    <= p_live;
        h_q    <= h_live;
        step_q <= step_live;
        mode_q <= mode_e'(mode);
      end
      acc_q  <= raw_val;
      out_q  <= out_d;
      tick_q <= tick_d;
      cnt_q  <= cnt_d;
    end else begin
      tick_q <= 1'b0;
    end
  end

  assign out         = out_q;
  assign period_tick = tick_q;

endmodule

// File: tb/tb_wave_osc.sv
// -----------------------------------------------------------------------------
// tb_wave_osc -- self-checking bench for wave_osc
//
// A behavioural model computes each sample directly from the waveform
// formulas (closed-form products, not running sums) and is compared against
// the DUT on every falling edge. Directed sections pin both the DUT and the
// model to hand-computed sequences; a randomized section then exercises
// enable/sync/reset interleavings and mid-period parameter changes.
// -----------------------------------------------------------------------------
module tb_wave_osc;

  localparam int    OUT_W     = 32;
  localparam int    CNT_W     = 32;
  localparam int    AMP_SHIFT = 20;
  localparam longint A        = longint'(1) << AMP_SHIFT;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic                    clk;
  logic                    reset;
  logic                    enable;
  logic                    sync;
  logic [1:0]              mode;
  logic [CNT_W-1:0]        wave_length;
  logic [7:0]              duty;
  logic signed [OUT_W-1:0] out_s;
  logic                    period_tick;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  wave_osc #(
    .OUT_W    (OUT_W),
    .CNT_W    (CNT_W),
    .AMP_SHIFT(AMP_SHIFT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .sync       (sync),
    .mode       (mode),
    .wave_length(wave_length),
    .duty       (duty),
    .out        (out_s),
    .period_tick(period_tick)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard counters and check helper
  // ---------------------------------------------------------------------------
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  longint m_cnt   = 0;
  longint m_p     = 2;
  longint m_h     = 0;
  longint m_step  = 0;
  longint m_out   = 0;
  int     m_mode  = 0;
  bit     m_tick  = 1'b0;
  bit     m_valid = 1'b0;

  function automatic longint f_model(input longint c);
    longint half;
    longint v;
    half = m_p / 2;
    case (m_mode)
      0:       v = (c < half) ? -A : A;
      1:       v = (c < m_h) ? A : -A;
      2:       v = -A + c * m_step;
      default: v = (c < half) ? (-A + c * 2 * m_step) : (A - (c - half) * 2 * m_step);
    endcase
    if (v > A)  v = A;
    if (v < -A) v = -A;
    return v;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_cnt   = 0;
      m_out   = 0;
      m_tick  = 1'b0;
      m_p     = 2;
      m_step  = 0;
      m_h     = 0;
      m_mode  = 0;
      m_valid = 1'b1;
    end else if (sync) begin
      m_cnt  = 0;
      m_tick = 1'b0;
    end else if (enable) begin
      if (m_cnt == 0) begin
        m_p    = (wave_length < 2) ? 2 : longint'(wave_length);
        m_mode = int'(mode);
        m_h    = (m_p * longint'(duty)) >> 8;
        m_step = (2 * A) / m_p;
      end
      m_out  = f_model(m_cnt);
      m_tick = (m_cnt == m_p - 1);
      m_cnt  = m_tick ? 0 : m_cnt + 1;
    end else begin
      m_tick = 1'b0;
    end
  end

  // Compare process: every cycle once the model has seen a reset.
  always @(negedge clk) begin
    if (m_valid) begin
      check("out_vs_model", longint'(out_s), m_out);
      check("tick_vs_model", longint'(period_tick), longint'(m_tick));
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  // One clock edge, then pin DUT and model to a hand-computed sample.
  task automatic edge_lit(input string name, input longint exp_out, input bit exp_tick);
    @(posedge clk);
    #1;
    check(name, longint'(out_s), exp_out);
    check({name, "_model"}, m_out, exp_out);
    check({name, "_tick"}, longint'(period_tick), longint'(exp_tick));
  endtask

  // Program new settings and restart the phase with one sync edge.
  task automatic restart(input logic [1:0] m, input logic [CNT_W-1:0] wl, input logic [7:0] d);
    mode        = m;
    wave_length = wl;
    duty        = d;
    sync        = 1'b1;
    @(posedge clk);
    #1;
    sync        = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  longint tri_exp [8];

  initial begin
    tri_exp = '{-A, -524288, 0, 524288, A, 524288, 0, -524288};

    reset       = 1'b1;
    enable      = 1'b0;
    sync        = 1'b0;
    mode        = 2'b00;
    wave_length = 32'd8;
    duty        = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_out", longint'(out_s), 0);
    check("reset_tick", longint'(period_tick), 0);

    // Square, P=8, straight out of reset.
    reset  = 1'b0;
    enable = 1'b1;
    for (int i = 0; i < 16; i++) edge_lit("sq8", ((i % 8) < 4) ? -A : A, (i % 8) == 7);

    // Pulse, P=16: duty 64 -> H=4, duty 255 -> H=15, duty 0 -> constant -A.
    restart(2'b01, 32'd16, 8'd64);
    for (int i = 0; i < 16; i++) edge_lit("pulse64", (i < 4) ? A : -A, i == 15);
    restart(2'b01, 32'd16, 8'd255);
    for (int i = 0; i < 16; i++) edge_lit("pulse255", (i < 15) ? A : -A, i == 15);
    restart(2'b01, 32'd16, 8'd0);
    for (int i = 0; i < 16; i++) edge_lit("pulse0", -A, i == 15);

    // Saw, P=8: step 262144.
    restart(2'b10, 32'd8, 8'd0);
    for (int i = 0; i < 16; i++) edge_lit("saw8", -1048576 + longint'(i % 8) * 262144, (i % 8) == 7);

    // Triangle, P=8.
    restart(2'b11, 32'd8, 8'd0);
    for (int i = 0; i < 16; i++) edge_lit("tri8", tri_exp[i % 8], (i % 8) == 7);

    // Period change 8 -> 4 at counter 3: old period finishes first.
    restart(2'b00, 32'd8, 8'd0);
    for (int i = 0; i < 3; i++) edge_lit("chg_pre", -A, 1'b0);
    wave_length = 32'd4;
    edge_lit("chg_c3", -A, 1'b0);
    for (int i = 4; i < 8; i++) edge_lit("chg_hi", A, i == 7);
    for (int i = 0; i < 4; i++) edge_lit("chg_p4", (i < 2) ? -A : A, i == 3);

    // Sync at counter 5: out holds on the sync edge, then f(0).
    restart(2'b00, 32'd8, 8'd0);
    for (int i = 0; i < 5; i++) edge_lit("sync_pre", (i < 4) ? -A : A, 1'b0);
    sync = 1'b1;
    edge_lit("sync_hold", A, 1'b0);
    sync = 1'b0;
    edge_lit("sync_f0", -A, 1'b0);

    // Enable low for 3 cycles mid-period: everything frozen, no tick.
    restart(2'b10, 32'd8, 8'd0);
    for (int i = 0; i < 3; i++) edge_lit("en_pre", -A + longint'(i) * 262144, 1'b0);
    enable = 1'b0;
    for (int i = 0; i < 3; i++) edge_lit("en_hold", -524288, 1'b0);
    enable = 1'b1;
    edge_lit("en_resume", -262144, 1'b0);

    // Reset mid-period: out clears, next edge restarts at f(0).
    reset = 1'b1;
    edge_lit("rst_mid", 0, 1'b0);
    reset = 1'b0;
    edge_lit("rst_f0", -A, 1'b0);

    // wave_length 0 and 1 behave as P=2.
    restart(2'b00, 32'd0, 8'd0);
    for (int i = 0; i < 6; i++) edge_lit("wl0", ((i % 2) == 0) ? -A : A, (i % 2) == 1);
    restart(2'b11, 32'd1, 8'd0);
    for (int i = 0; i < 4; i++) edge_lit("wl1_tri", ((i % 2) == 0) ? -A : A, (i % 2) == 1);

    // Randomized interleavings checked by the compare process.
    for (int i = 0; i < 5000; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        mode        = 2'($urandom_range(0, 3));
        wave_length = 32'($urandom_range(0, 24));
        duty        = 8'($urandom_range(0, 255));
      end
      if ($urandom_range(0, 49) == 0) duty = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'd255;
      enable = ($urandom_range(0, 4) != 0);
      sync   = ($urandom_range(0, 39) == 0);
      reset  = ($urandom_range(0, 149) == 0);
      @(posedge clk);
      #1;
    end
    reset  = 1'b0;
    sync   = 1'b0;
    enable = 1'b0;
    @(posedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
